// File: rtl/crc32_pkg.sv
// crc32_pkg: shared constants, types and the bytewise update function for the
// streaming CRC-32 engine (reflected Ethernet CRC-32).
//   CRC32_*_ETH   : standard Ethernet polynomial / init / xor-out / residue
//   crc32_state_t : frame-tracking state of crc32_stream
//   crc32_byte    : folds one byte into a reflected CRC register
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_ETH    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT_ETH    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT_ETH  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_ETH = 32'hDEBB20E3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } crc32_state_t;

  // LSB-first (reflected) update: the byte is XORed into the low bits and
  // shifted out to the right one bit at a time.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data,
                                             input logic [31:0] poly);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ poly) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_beat.sv
// crc32_beat: combinational CRC update for one input beat of DATA_BYTES bytes.
// Bytes with keep set are folded in ascending order; cleared bytes are skipped.
//   crc_in  : running register before the beat
//   data    : beat payload, byte 0 in bits [7:0]
//   keep    : per-byte enables
//   crc_out : running register after the beat
module crc32_beat
  import crc32_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC32_POLY_ETH
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [31:0]             crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (keep[k]) begin
        crc_out = crc32_byte(crc_out, data[8*k +: 8], POLY);
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream: multi-byte streaming CRC-32 engine with framing and length count.
// Consumes a valid/ready byte stream (DATA_BYTES per beat, byte enables, end of
// frame marker) and emits one registered CRC/length result per frame.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : input beat handshake
//   s_data/s_keep     : beat payload and contiguous byte enables
//   s_last            : beat closes the frame
//   m_valid/m_ready   : result handshake
//   m_crc             : final CRC (register ^ XOR_OUT)
//   m_len             : frame byte count, saturating
//   m_fcs_ok          : received FCS matches, only when CRC32_CHECK_EN is defined
// Optional feature macro: CRC32_CHECK_EN (adds m_fcs_ok and the residue compare).
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC32_POLY_ETH,
  parameter logic [31:0] INIT       = CRC32_INIT_ETH,
  parameter logic [31:0] XOR_OUT    = CRC32_XOROUT_ETH,
  parameter logic [31:0] RESIDUE    = CRC32_RESIDUE_ETH,
  parameter int          LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [31:0]             m_crc,
  output logic [LEN_WIDTH-1:0]    m_len
`ifdef CRC32_CHECK_EN
  ,
  output logic                    m_fcs_ok
`endif
);

  localparam int SUM_W = LEN_WIDTH + 5;

  crc32_state_t         state_q, state_d;
  logic [31:0]          crc_q, crc_d, crc_next;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_next;
  logic [SUM_W-1:0]     cnt_sum;
  logic [4:0]           keep_cnt;
  logic                 m_valid_q, m_valid_d;
  logic [31:0]          m_crc_q, m_crc_d;
  logic [LEN_WIDTH-1:0] m_len_q, m_len_d;
  logic                 beat_fire;
  logic [DATA_BYTES-1:0] keep_plus1;
`ifdef CRC32_CHECK_EN
  logic                 fcs_ok_q, fcs_ok_d;
`endif

  // A pending result blocks every input beat, mid-frame ones included; this
  // keeps the datapath free of any skid storage.
  assign s_ready   = ~m_valid_q | m_ready;
  assign beat_fire = s_valid & s_ready;

  crc32_beat #(
    .DATA_BYTES (DATA_BYTES),
    .POLY       (POLY)
  ) u_beat (
    .crc_in  (crc_q),
    .data    (s_data),
    .keep    (s_keep),
    .crc_out (crc_next)
  );

  always_comb begin
    keep_cnt = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      keep_cnt = keep_cnt + {4'b0, s_keep[k]};
    end
  end

  // Widened sum so saturation can be detected from the overflow bits.
  assign cnt_sum  = SUM_W'(cnt_q) + SUM_W'(keep_cnt);
  assign cnt_next = (|cnt_sum[SUM_W-1:LEN_WIDTH]) ? '1 : cnt_sum[LEN_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_crc_d   = m_crc_q;
    m_len_d   = m_len_q;
`ifdef CRC32_CHECK_EN
    fcs_ok_d  = fcs_ok_q;
`endif
    if (beat_fire) begin
      if (s_last) begin
        // Publish the result and rearm for the next frame on the same edge.
        state_d   = IDLE;
        crc_d     = INIT;
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_crc_d   = crc_next ^ XOR_OUT;
        m_len_d   = cnt_next;
`ifdef CRC32_CHECK_EN
        fcs_ok_d  = (crc_next == RESIDUE);
`endif
      end else begin
        crc_d = crc_next;
        cnt_d = cnt_next;
        // An all-zero keep beat carries no bytes and leaves the frame state alone.
        if (|s_keep) begin
          state_d = ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_len_q   <= '0;
`ifdef CRC32_CHECK_EN
      fcs_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_len_q   <= m_len_d;
`ifdef CRC32_CHECK_EN
      fcs_ok_q  <= fcs_ok_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_crc   = m_crc_q;
  assign m_len   = m_len_q;
`ifdef CRC32_CHECK_EN
  assign m_fcs_ok = fcs_ok_q;
`endif

  // Enables must be a run of ones starting at byte 0 (x & (x+1) == 0).
  assign keep_plus1 = s_keep + DATA_BYTES'(1);

  a_keep_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
    beat_fire |-> ((s_keep & keep_plus1) == '0));

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: directed, self-checking bench for crc32_stream (DATA_BYTES=4).
// Build with CRC32_CHECK_EN defined to also exercise m_fcs_ok.
module tb_crc32_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_crc;
  logic [15:0] m_len;
`ifdef CRC32_CHECK_EN
  logic        m_fcs_ok;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] got_crc[$];
  logic [15:0] got_len[$];

  always #5 clk = ~clk;

  crc32_stream #(
    .DATA_BYTES (4),
    .LEN_WIDTH  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_crc   (m_crc),
    .m_len   (m_len)
`ifdef CRC32_CHECK_EN
    ,
    .m_fcs_ok (m_fcs_ok)
`endif
  );

  // Record every result handshake, sampled half a cycle before the edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_crc.push_back(m_crc);
      got_len.push_back(m_len);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a beat and hold it until accepted; returns 1 time unit after the edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) check("s_ready_timeout", {63'b0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_keep  = '0;
  endtask

  task automatic send_123456789();
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] crc, input logic [15:0] len);
    check({tag, "_valid"}, {63'b0, m_valid}, 64'd1);
    check({tag, "_crc"}, {32'b0, m_crc}, {32'b0, crc});
    check({tag, "_len"}, {48'b0, m_len}, {48'b0, len});
  endtask

  task automatic consume(input string tag);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_drop"}, {63'b0, m_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    check("rst_m_valid", {63'b0, m_valid}, 64'd0);
    check("rst_m_crc", {32'b0, m_crc}, 64'd0);
    check("rst_m_len", {48'b0, m_len}, 64'd0);
    check("rst_s_ready", {63'b0, s_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Check string over three beats
    send_123456789();
    expect_result("check9", 32'hCBF43926, 16'd9);
    consume("check9");

    // Single-byte frames
    send_beat(32'h00000000, 4'h1, 1'b1);
    expect_result("byte00", 32'hD202EF8D, 16'd1);
    consume("byte00");
    send_beat(32'h00000061, 4'h1, 1'b1);
    expect_result("byte61", 32'hE8B7BE43, 16'd1);
    consume("byte61");

    // Empty frame
    send_beat(32'hDEADBEEF, 4'h0, 1'b1);
    expect_result("empty", 32'h00000000, 16'd0);
    consume("empty");

    // Zero-keep beat inside a frame must not disturb CRC or length
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'hFFFFFFFF, 4'h0, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    expect_result("keep0", 32'hCBF43926, 16'd9);
    consume("keep0");

    // Back-to-back frames with the sink always ready
    got_crc.delete();
    got_len.delete();
    m_ready = 1'b1;
    send_123456789();
    send_123456789();
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("b2b_count", 64'(got_crc.size()), 64'd2);
    check("b2b_idle", {63'b0, m_valid}, 64'd0);
    if (got_crc.size() >= 2) begin
      check("b2b_crc0", {32'b0, got_crc[0]}, 64'hCBF43926);
      check("b2b_crc1", {32'b0, got_crc[1]}, 64'hCBF43926);
      check("b2b_len0", {48'b0, got_len[0]}, 64'd9);
      check("b2b_len1", {48'b0, got_len[1]}, 64'd9);
    end

    // Result held under back-pressure for 10 cycles
    send_123456789();
    expect_result("hold", 32'hCBF43926, 16'd9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_s_ready", {63'b0, s_ready}, 64'd0);
      check("hold_m_valid", {63'b0, m_valid}, 64'd1);
      check("hold_m_crc", {32'b0, m_crc}, 64'hCBF43926);
      check("hold_m_len", {48'b0, m_len}, 64'd9);
    end
    @(posedge clk);
    #1;
    // Consume old result and accept a new last beat on the same edge
    m_ready = 1'b1;
    send_beat(32'h00000061, 4'h1, 1'b1);
    expect_result("replace", 32'hE8B7BE43, 16'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("replace_drop", {63'b0, m_valid}, 64'd0);

    // Reset in the middle of a frame discards the partial frame
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_m_valid", {63'b0, m_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_result", {63'b0, m_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send_123456789();
    expect_result("after_rst", 32'hCBF43926, 16'd9);
    consume("after_rst");

`ifdef CRC32_CHECK_EN
    // Frame carrying its own FCS, LSB first
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'hF4392639, 4'hF, 1'b0);
    send_beat(32'h000000CB, 4'h1, 1'b1);
    expect_result("fcs_good", 32'h2144DF1C, 16'd13);
    check("fcs_good_ok", {63'b0, m_fcs_ok}, 64'd1);
    consume("fcs_good");
    // Same frame with one data bit flipped
    send_beat(32'h34333230, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'hF4392639, 4'hF, 1'b0);
    send_beat(32'h000000CB, 4'h1, 1'b1);
    check("fcs_bad_ok", {63'b0, m_fcs_ok}, 64'd0);
    consume("fcs_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Parametrised multi-byte CRC engine for Ethernet frame paths: consumes a valid/ready byte stream of DATA_BYTES bytes per beat with byte-enable and end-of-frame marker.
- Produces one CRC result per frame through a registered valid/ready output.
- Sits beside the MAC TX/RX datapath: on TX it generates the FCS to append; on RX it checks the received FCS.
- Successor of the single-byte crc32b engine; adds bus-width generality, framing, length counting and back-pressure.

Parameters:
- DATA_BYTES, 4, bytes per input beat (1..16).
- POLY, 32'hEDB88320, reflected generator polynomial.
- INIT, 32'hFFFFFFFF, running-register value at start of each frame.
- XOR_OUT, 32'hFFFFFFFF, XORed into the register to form m_crc.
- RESIDUE, 32'hDEBB20E3, register value after data+valid FCS; used only with CRC32_CHECK_EN.
- LEN_WIDTH, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  8*DATA_BYTES  byte 0 in bits [7:0], processed first.
- s_keep  in  DATA_BYTES  byte enables; contiguous from bit 0.
- s_last  in  1  beat ends the frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_crc  out  32  final CRC (register ^ XOR_OUT).
- m_len  out  LEN_WIDTH  frame byte count, saturating.
- m_fcs_ok  out  1  only with CRC32_CHECK_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_valid=0, m_crc=0, m_len=0, m_fcs_ok=0.
  - Running register=INIT, byte counter=0, state=IDLE.
- States:
  - IDLE: no bytes of current frame accepted. Any accepted beat with s_last=0 -> ACTIVE. Accepted beat with s_last=1 -> IDLE, result loaded.
  - ACTIVE: mid-frame. Accepted beat with s_last=1 -> IDLE, result loaded.
- Per accepted beat:
  - For k=0..DATA_BYTES-1 with s_keep[k]=1, in ascending k: reg ^= byte k, then 8 iterations of reg = (reg>>1) ^ (reg[0] ? POLY : 0).
  - Fully combinational within one cycle; counter += popcount(s_keep), saturating at all-ones.
- s_keep:
  - Non-contiguous s_keep is illegal; covered by an assertion, result undefined.
  - s_keep=0 on a non-last beat: no state change other than the handshake.
- Last beat accepted:
  - Next cycle: m_valid=1, m_crc=reg_next^XOR_OUT, m_len=count_next.
  - Same edge: reg=INIT, counter=0.
  - Latency: result valid 1 cycle after the last-beat handshake.
- Empty frame (s_last with s_keep=0 in IDLE): m_crc=INIT^XOR_OUT, m_len=0.
- Output hold: m_valid stays high, and m_crc/m_len/m_fcs_ok stay stable, until m_ready; m_valid falls the cycle after the handshake unless a new result loads on the same edge.
- Back-pressure: s_ready = ~m_valid | m_ready.
  - Mid-frame beats are also stalled while a result is pending; simple, no skid buffer.
  - Result handshake and new last-beat acceptance in the same cycle: new result replaces the old one; m_valid stays 1.
- rst_n asserted mid-frame: partial frame discarded, no result emitted.

Optional Feature:
- Macro: CRC32_CHECK_EN.
- Defined:
  - m_fcs_ok = (reg_next == RESIDUE), registered with m_crc.
  - Meaningful when the frame includes its 4-byte FCS, least significant byte first.
- Undefined: m_fcs_ok port absent and no compare logic is built.

Decomposition:
- Package crc32_pkg:
  - Constants CRC32_POLY_ETH, CRC32_INIT_ETH, CRC32_XOROUT_ETH, CRC32_RESIDUE_ETH.
  - typedef enum {IDLE, ACTIVE} crc32_state_t.
  - Function crc32_byte(reg, byte, poly) doing the 8-iteration update.
- Sub-module crc32_beat: combinational, DATA_BYTES-wide, keep-masked chain of crc32_byte; instantiated once.

Test Plan:
- DATA_BYTES=4, frame "123456789" as beats keep=F,F,1 -> m_crc=32'hCBF43926, m_len=9, one cycle after last handshake.
- DATA_BYTES=1, single byte 8'h00 -> 32'hD202EF8D; single byte 8'h61 -> 32'hE8B7BE43.
- Empty frame (s_last, s_keep=0) -> m_crc=32'h00000000, m_len=0; back-to-back 9-byte frames with m_ready=1 -> two correct results, no lost beats.
- m_ready held 0 for 10 cycles after a result -> s_ready=0, m_crc stable throughout; m_ready=1 with a new last beat in the same cycle -> m_valid stays 1, new value loaded.
- rst_n pulsed low after 2 beats of a frame -> no m_valid; next frame "123456789" -> 32'hCBF43926.
- CRC32_CHECK_EN: "123456789" followed by 8'h26,8'h39,8'hF4,8'hCB -> m_fcs_ok=1, m_crc=32'h2144DF1C; corrupt one data bit -> m_fcs_ok=0.
